// File: rtl/dynamic_output_rr_arbiter.sv
// Round-robin wormhole arbiter with a local downstream credit counter for one output port; grant is combinational.
// A flit leaves only while a credit is held; a locked route keeps the port until its tail flit, and other routes wait.
module dynamic_output_rr_arbiter #(
  parameter int NUM_CREDITS = 4,
  parameter int CREDIT_W    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                route_req_0_in,
  input  logic                route_req_1_in,
  input  logic                route_req_2_in,
  input  logic                route_req_3_in,
  input  logic                valid_0_in,
  input  logic                valid_1_in,
  input  logic                valid_2_in,
  input  logic                valid_3_in,
  input  logic                tail_0_in,
  input  logic                tail_1_in,
  input  logic                tail_2_in,
  input  logic                tail_3_in,
  input  logic                yummy_in,
  output logic [1:0]          current_route,
  output logic                valid_out,
  output logic                thanks_0_out,
  output logic                thanks_1_out,
  output logic                thanks_2_out,
  output logic                thanks_3_out,
  output logic [CREDIT_W-1:0] credits_out,
  output logic                locked_out,
  output logic                ec_wants_to_send_but_cannot
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state, state_nxt;
  logic [1:0]          lock_route, lock_route_nxt;
  logic [1:0]          rr_ptr, rr_ptr_nxt;
  logic [CREDIT_W-1:0] credits, credits_nxt;
  logic [3:0]          vld, tail, elig, thanks;
  logic [1:0]          winner, idx;
  logic                any_elig, can_send;

  assign vld      = {valid_3_in, valid_2_in, valid_1_in, valid_0_in};
  assign tail     = {tail_3_in, tail_2_in, tail_1_in, tail_0_in};
  assign elig     = {route_req_3_in, route_req_2_in, route_req_1_in, route_req_0_in} & vld;
  assign can_send = (credits != '0);

  // Scan from farthest to nearest so the route closest to rr_ptr is the last write and wins.
  always_comb begin
    winner   = rr_ptr;
    any_elig = 1'b0;
    idx      = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = rr_ptr + 2'(k);
      if (elig[idx]) begin
        winner   = idx;
        any_elig = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    lock_route_nxt = lock_route;
    rr_ptr_nxt     = rr_ptr;
    current_route  = rr_ptr;
    valid_out      = 1'b0;
    thanks         = 4'b0000;
    ec_wants_to_send_but_cannot = 1'b0;
    if (state == IDLE) begin
      ec_wants_to_send_but_cannot = any_elig & ~can_send;
      // Never lock a route without a credit in hand.
      if (any_elig && can_send) begin
        current_route  = winner;
        valid_out      = 1'b1;
        thanks[winner] = 1'b1;
        if (tail[winner]) begin
          rr_ptr_nxt = winner + 2'd1;
        end else begin
          state_nxt      = LOCKED;
          lock_route_nxt = winner;
        end
      end
    end else begin
      current_route               = lock_route;
      valid_out                   = vld[lock_route] & can_send;
      thanks[lock_route]          = valid_out;
      ec_wants_to_send_but_cannot = vld[lock_route] & ~can_send;
      if (valid_out && tail[lock_route]) begin
        state_nxt  = IDLE;
        rr_ptr_nxt = lock_route + 2'd1;
      end
    end

    credits_nxt = credits;
    if (valid_out && !yummy_in) begin
      credits_nxt = credits - CREDIT_W'(1);
    end else if (yummy_in && !valid_out && credits != CREDIT_W'(NUM_CREDITS)) begin
      credits_nxt = credits + CREDIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lock_route <= 2'd0;
      rr_ptr     <= 2'd0;
      credits    <= CREDIT_W'(NUM_CREDITS);
    end else begin
      state      <= state_nxt;
      lock_route <= lock_route_nxt;
      rr_ptr     <= rr_ptr_nxt;
      credits    <= credits_nxt;
    end
  end

  assign thanks_0_out = thanks[0];
  assign thanks_1_out = thanks[1];
  assign thanks_2_out = thanks[2];
  assign thanks_3_out = thanks[3];
  assign credits_out  = credits;
  assign locked_out   = (state == LOCKED);

endmodule

// File: tb/tb_dynamic_output_rr_arbiter.sv
// Directed, table-driven bench for dynamic_output_rr_arbiter; each record holds one cycle's
// inputs and the outputs expected in that cycle (credits/locked reflect state before the edge).
module tb_dynamic_output_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, vld, tail;
  logic       yummy;
  logic [1:0] current_route;
  logic       valid_out, locked_out, ec;
  logic       th0, th1, th2, th3;
  logic [2:0] credits_out;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  dynamic_output_rr_arbiter #(.NUM_CREDITS(4), .CREDIT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .route_req_0_in(req[0]), .route_req_1_in(req[1]),
    .route_req_2_in(req[2]), .route_req_3_in(req[3]),
    .valid_0_in(vld[0]), .valid_1_in(vld[1]), .valid_2_in(vld[2]), .valid_3_in(vld[3]),
    .tail_0_in(tail[0]), .tail_1_in(tail[1]), .tail_2_in(tail[2]), .tail_3_in(tail[3]),
    .yummy_in(yummy),
    .current_route(current_route), .valid_out(valid_out),
    .thanks_0_out(th0), .thanks_1_out(th1), .thanks_2_out(th2), .thanks_3_out(th3),
    .credits_out(credits_out), .locked_out(locked_out),
    .ec_wants_to_send_but_cannot(ec)
  );

  typedef struct {
    logic [3:0] req, vld, tail;
    logic       yummy;
    logic       e_valid;
    logic [3:0] e_thanks;
    logic [1:0] e_route;
    logic [2:0] e_credits;
    logic       e_locked;
    logic       e_ec;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [3:0] r, v, t, input logic y,
                     input logic ev, input logic [3:0] et, input logic [1:0] er,
                     input logic [2:0] ec_cr, input logic el, input logic ee);
    vec_t x;
    x.req = r; x.vld = v; x.tail = t; x.yummy = y;
    x.e_valid = ev; x.e_thanks = et; x.e_route = er;
    x.e_credits = ec_cr; x.e_locked = el; x.e_ec = ee;
    vq.push_back(x);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  function automatic logic [6:0] grant_word();
    return {valid_out, th3, th2, th1, th0, current_route};
  endfunction

  function automatic logic [4:0] state_word();
    return {credits_out, locked_out, ec};
  endfunction

  initial begin
    //   req    vld    tail   y   valid thanks route cred lock ec
    add(4'h0, 4'h0, 4'h0, 0,   0, 4'h0, 2'd0, 3'd4, 0, 0); // post-reset idle
    add(4'h4, 4'h4, 4'h4, 0,   1, 4'h4, 2'd2, 3'd4, 0, 0); // single-flit route 2
    add(4'h0, 4'h0, 4'h0, 0,   0, 4'h0, 2'd3, 3'd3, 0, 0); // rr_ptr now 3
    add(4'h0, 4'h0, 4'h0, 1,   0, 4'h0, 2'd3, 3'd3, 0, 0);
    add(4'h3, 4'h3, 4'h0, 0,   1, 4'h1, 2'd0, 3'd4, 0, 0); // route 0 header beats 1
    add(4'h2, 4'h3, 4'h0, 0,   1, 4'h1, 2'd0, 3'd3, 1, 0); // body, route 1 held off
    add(4'h2, 4'h3, 4'h1, 0,   1, 4'h1, 2'd0, 3'd2, 1, 0); // tail
    add(4'h2, 4'h2, 4'h2, 1,   1, 4'h2, 2'd1, 3'd1, 0, 0); // route 1 next cycle, send+yummy
    add(4'h0, 4'h0, 4'h0, 1,   0, 4'h0, 2'd2, 3'd1, 0, 0);
    add(4'h0, 4'h0, 4'h0, 1,   0, 4'h0, 2'd2, 3'd2, 0, 0);
    add(4'h0, 4'h0, 4'h0, 1,   0, 4'h0, 2'd2, 3'd3, 0, 0);
    add(4'hF, 4'hF, 4'hF, 0,   1, 4'h4, 2'd2, 3'd4, 0, 0); // round-robin sweep
    add(4'hF, 4'hF, 4'hF, 1,   1, 4'h8, 2'd3, 3'd3, 0, 0);
    add(4'hF, 4'hF, 4'hF, 1,   1, 4'h1, 2'd0, 3'd3, 0, 0);
    add(4'hF, 4'hF, 4'hF, 1,   1, 4'h2, 2'd1, 3'd3, 0, 0);
    add(4'hF, 4'hF, 4'hF, 1,   1, 4'h4, 2'd2, 3'd3, 0, 0);
    add(4'h0, 4'h0, 4'h0, 1,   0, 4'h0, 2'd3, 3'd3, 0, 0);
    add(4'h8, 4'h8, 4'h0, 0,   1, 4'h8, 2'd3, 3'd4, 0, 0); // route 3, 6 flits, no yummy
    add(4'h0, 4'h8, 4'h0, 0,   1, 4'h8, 2'd3, 3'd3, 1, 0);
    add(4'h0, 4'h8, 4'h0, 0,   1, 4'h8, 2'd3, 3'd2, 1, 0);
    add(4'h0, 4'h8, 4'h0, 0,   1, 4'h8, 2'd3, 3'd1, 1, 0);
    add(4'h0, 4'h8, 4'h0, 0,   0, 4'h0, 2'd3, 3'd0, 1, 1); // stalled
    add(4'h1, 4'h9, 4'h0, 1,   0, 4'h0, 2'd3, 3'd0, 1, 1); // stalled, route 0 ignored, yummy
    add(4'h0, 4'h8, 4'h0, 0,   1, 4'h8, 2'd3, 3'd1, 1, 0); // exactly one flit released
    add(4'h0, 4'h8, 4'h0, 1,   0, 4'h0, 2'd3, 3'd0, 1, 1);
    add(4'h0, 4'h8, 4'h8, 0,   1, 4'h8, 2'd3, 3'd1, 1, 0); // tail
    add(4'h2, 4'h2, 4'h2, 1,   0, 4'h0, 2'd0, 3'd0, 0, 1); // idle, no credit, no lock
    add(4'h2, 4'h2, 4'h2, 1,   1, 4'h2, 2'd1, 3'd1, 0, 0);
    add(4'h0, 4'h0, 4'h0, 1,   0, 4'h0, 2'd2, 3'd1, 0, 0);
    add(4'h4, 4'h4, 4'h4, 1,   1, 4'h4, 2'd2, 3'd2, 0, 0); // send+yummy at 2
    add(4'h0, 4'h0, 4'h0, 1,   0, 4'h0, 2'd3, 3'd2, 0, 0);
    add(4'h0, 4'h0, 4'h0, 1,   0, 4'h0, 2'd3, 3'd3, 0, 0);
    add(4'h0, 4'h0, 4'h0, 1,   0, 4'h0, 2'd3, 3'd4, 0, 0); // yummy at full credit
    add(4'h0, 4'h0, 4'h0, 0,   0, 4'h0, 2'd3, 3'd4, 0, 0);
    add(4'h1, 4'h2, 4'h0, 0,   0, 4'h0, 2'd3, 3'd4, 0, 0); // req and valid on different routes
    add(4'h2, 4'h2, 4'h0, 0,   1, 4'h2, 2'd1, 3'd4, 0, 0); // lock route 1
    add(4'h0, 4'h2, 4'h0, 0,   1, 4'h2, 2'd1, 3'd3, 1, 0);
    add(4'h0, 4'h2, 4'h0, 0,   1, 4'h2, 2'd1, 3'd2, 1, 0);

    rst_n = 1'b0; req = '0; vld = '0; tail = '0; yummy = 1'b0;
    #12;
    check("reset_state", -1, {27'd0, state_word()}, {27'd0, 3'd4, 1'b0, 1'b0});
    check("reset_grant", -1, {25'd0, grant_word()}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      req = vq[i].req; vld = vq[i].vld; tail = vq[i].tail; yummy = vq[i].yummy;
      #2;
      check("grant", i, {25'd0, grant_word()},
            {25'd0, vq[i].e_valid, vq[i].e_thanks, vq[i].e_route});
      check("state", i, {27'd0, state_word()},
            {27'd0, vq[i].e_credits, vq[i].e_locked, vq[i].e_ec});
    end

    // Mid-packet reset: locked on route 1 holding one credit, reset between edges.
    @(negedge clk);
    req = '0; vld = '0; tail = '0; yummy = 1'b0;
    #2;
    check("pre_reset", 100, {27'd0, state_word()}, {27'd0, 3'd1, 1'b1, 1'b0});
    rst_n = 1'b0;
    #1;
    check("async_reset_state", 101, {27'd0, state_word()}, {27'd0, 3'd4, 1'b0, 1'b0});
    check("async_reset_route", 102, {30'd0, current_route}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'h9; vld = 4'h9; tail = 4'h9;
    #2;
    check("post_reset_grant", 103, {25'd0, grant_word()}, {25'd0, 1'b1, 4'h1, 2'd0});
    @(negedge clk);
    req = '0; vld = '0; tail = '0;
    #2;
    check("post_reset_credits", 104, {27'd0, state_word()}, {27'd0, 3'd3, 1'b0, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
